reg_bus_arbiter: RTL and testbench

- Shares the single register-bus port of the SPI register file between up to N_REQ requesters, e.g. the SPI slave, local motor/sensor FSMs and a debug port.
- Grants one transaction at a time in round-robin order and drives the shared bus.
- Waits for the register file's acknowledge, or times out, and returns read data and completion status to the granted requester.
- Sits between the requesters and the register decode/storage logic.

---
 rtl/reg_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_reg_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the register-file bus between N_REQ requesters.
// One transaction at a time; completes on bus_ack or on a TIMEOUT-cycle watchdog.
module reg_bus_arbiter #(
  parameter int              N_REQ    = 4,
  parameter int              AW       = 15,
  parameter int              DW       = 16,
  parameter int              TIMEOUT  = 255,
  parameter logic [DW-1:0]   ERR_DATA = 16'hDEAD
) (
  input  logic                theClock,
  input  logic                theReset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_write,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    req_accept,
  output logic [N_REQ-1:0]    req_done,
  output logic                req_err,
  output logic [DW-1:0]       req_rdata,
  output logic                bus_valid,
  output logic                bus_write,
  output logic [AW-1:0]       bus_addr,
  output logic [DW-1:0]       bus_wdata,
  input  logic                bus_ack,
  input  logic [DW-1:0]       bus_rdata
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   grant_idx;
  logic [CW-1:0]   timeout_cnt;

  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  int              cand;

  // Round-robin search: first pending request at or after rr_ptr, wrapping.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!pick_valid && req_valid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(cand);
      end
    end
  end

  function automatic logic [N_REQ-1:0] one_hot(input logic [PW-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return (idx == PW'(N_REQ - 1)) ? '0 : idx + PW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge theClock) begin
    if (!theReset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_idx   <= '0;
      timeout_cnt <= '0;
      req_accept  <= '0;
      req_done    <= '0;
      req_err     <= 1'b0;
      req_rdata   <= '0;
      bus_valid   <= 1'b0;
      bus_write   <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
    end else begin
      req_accept <= '0;
      req_done   <= '0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_idx   <= pick_idx;
            bus_write   <= req_write[pick_idx];
            bus_addr    <= req_addr[int'(pick_idx)*AW +: AW];
            bus_wdata   <= req_wdata[int'(pick_idx)*DW +: DW];
            bus_valid   <= 1'b1;
            req_accept  <= one_hot(pick_idx);
            timeout_cnt <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          // An ack landing on the last allowed cycle still counts as success.
          if (bus_ack) begin
            req_rdata <= bus_rdata;
            req_err   <= 1'b0;
            req_done  <= one_hot(grant_idx);
            bus_valid <= 1'b0;
            state     <= DONE;
          end else if (timeout_cnt == CW'(TIMEOUT - 1)) begin
            req_rdata <= ERR_DATA;
            req_err   <= 1'b1;
            req_done  <= one_hot(grant_idx);
            bus_valid <= 1'b0;
            state     <= DONE;
          end else begin
            timeout_cnt <= timeout_cnt + CW'(1);
          end
        end
        DONE: begin
          rr_ptr <= next_ptr(grant_idx);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: single read, round robin, timeout,
// boundary ack, reset abort, spurious ack and a request queued during BUSY.
module tb_reg_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int TO = 8;

  logic            theClock = 1'b0;
  logic            theReset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_accept;
  logic [N-1:0]    req_done;
  logic            req_err;
  logic [DW-1:0]   req_rdata;
  logic            bus_valid;
  logic            bus_write;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic            bus_ack;
  logic [DW-1:0]   bus_rdata;

  always #5 theClock = ~theClock;

  reg_bus_arbiter #(
    .N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO), .ERR_DATA(16'hDEAD)
  ) dut (
    .theClock   (theClock),
    .theReset   (theReset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_accept (req_accept),
    .req_done   (req_done),
    .req_err    (req_err),
    .req_rdata  (req_rdata),
    .bus_valid  (bus_valid),
    .bus_write  (bus_write),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge theClock);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    theReset  = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    tick();
    tick();
    check("rst_bus_valid", bus_valid, 0);
    check("rst_accept", req_accept, 0);
    check("rst_done", req_done, 0);
    check("rst_rdata", req_rdata, 0);
    check("rst_err", req_err, 0);
    theReset = 1'b1;

    // 1. single read from requester 1, ack two cycles after bus_valid
    set_req(1, 1'b0, 15'h02, 16'h0);
    req_valid = 4'b0010;
    tick();
    check("t1_accept", req_accept, 4'b0010);
    check("t1_bus_valid", bus_valid, 1);
    check("t1_bus_addr", bus_addr, 15'h02);
    check("t1_bus_write", bus_write, 0);
    req_valid = '0;
    tick();
    check("t1_accept_pulse", req_accept, 0);
    tick();
    bus_ack   = 1'b1;
    bus_rdata = 16'h00A5;
    tick();
    check("t1_done", req_done, 4'b0010);
    check("t1_rdata", req_rdata, 16'h00A5);
    check("t1_err", req_err, 0);
    check("t1_bus_drop", bus_valid, 0);
    bus_ack = 1'b0;
    tick();
    check("t1_done_pulse", req_done, 0);

    // 2. round robin with all four requesting; reset first so rr_ptr starts at 0
    theReset = 1'b0;
    tick();
    theReset = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 15'(15'h100 + i), 16'h0);
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      automatic int g = t % N;
      automatic logic [N-1:0] oh = 4'b0001 << g;
      tick();
      check("t2_accept", req_accept, oh);
      check("t2_addr", bus_addr, 32'h100 + g);
      if (t == 4) req_valid = '0;
      bus_ack   = 1'b1;
      bus_rdata = 16'(16'h5000 + g);
      tick();
      check("t2_done", req_done, oh);
      check("t2_rdata", req_rdata, 32'h5000 + g);
      bus_ack = 1'b0;
      tick();
      check("t2_rr_ptr", dut.rr_ptr, (g + 1) % N);
    end

    // 3. timeout on a write from requester 2
    set_req(2, 1'b1, 15'h11, 16'h1234);
    req_valid = 4'b0100;
    tick();
    check("t3_accept", req_accept, 4'b0100);
    check("t3_bus_write", bus_write, 1);
    check("t3_bus_wdata", bus_wdata, 16'h1234);
    req_valid = '0;
    n = 0;
    while (bus_valid && n < 20) begin
      n++;
      tick();
    end
    check("t3_valid_cycles", n, TO);
    check("t3_done", req_done, 4'b0100);
    check("t3_err", req_err, 1);
    check("t3_rdata", req_rdata, 16'hDEAD);
    tick();

    // 4. ack in the same cycle the counter reaches TIMEOUT-1
    set_req(0, 1'b0, 15'h22, 16'h0);
    req_valid = 4'b0001;
    tick();
    check("t4_accept", req_accept, 4'b0001);
    req_valid = '0;
    for (int i = 0; i < TO - 1; i++) tick();
    check("t4_still_valid", bus_valid, 1);
    bus_ack   = 1'b1;
    bus_rdata = 16'h0042;
    tick();
    check("t4_done", req_done, 4'b0001);
    check("t4_err", req_err, 0);
    check("t4_rdata", req_rdata, 16'h0042);
    bus_ack = 1'b0;
    tick();

    // 5. reset during BUSY aborts with no completion
    set_req(1, 1'b0, 15'h33, 16'h0);
    req_valid = 4'b0010;
    tick();
    check("t5_accept", req_accept, 4'b0010);
    req_valid = '0;
    tick();
    tick();
    theReset = 1'b0;
    tick();
    check("t5_bus_valid", bus_valid, 0);
    check("t5_bus_addr", bus_addr, 0);
    check("t5_rdata", req_rdata, 0);
    check("t5_done", req_done, 0);
    check("t5_rr_ptr", dut.rr_ptr, 0);
    theReset = 1'b1;
    tick();
    check("t5_no_done", req_done, 0);
    set_req(3, 1'b1, 15'h7FFF, 16'hBEEF);
    req_valid = 4'b1000;
    tick();
    check("t5_accept3", req_accept, 4'b1000);
    check("t5_addr3", bus_addr, 15'h7FFF);
    check("t5_wdata3", bus_wdata, 16'hBEEF);
    req_valid = '0;
    bus_ack   = 1'b1;
    bus_rdata = 16'h0000;
    tick();
    check("t5_done3", req_done, 4'b1000);
    bus_ack = 1'b0;
    tick();

    // 6. spurious ack in IDLE, then a request queued during another's BUSY
    bus_ack   = 1'b1;
    bus_rdata = 16'hFFFF;
    tick();
    check("t6_spur_done", req_done, 0);
    check("t6_spur_valid", bus_valid, 0);
    tick();
    check("t6_spur_rdata", req_rdata, 0);
    bus_ack = 1'b0;
    set_req(2, 1'b0, 15'h55, 16'h0);
    req_valid = 4'b0100;
    tick();
    check("t6_accept2", req_accept, 4'b0100);
    set_req(0, 1'b1, 15'h44, 16'hCAFE);
    req_valid = 4'b0001;
    tick();
    check("t6_wait_busy", req_accept, 0);
    bus_ack   = 1'b1;
    bus_rdata = 16'h0077;
    tick();
    check("t6_done2", req_done, 4'b0100);
    check("t6_rdata2", req_rdata, 16'h0077);
    check("t6_wait_done", req_accept, 0);
    bus_ack = 1'b0;
    tick();
    check("t6_wait_idle", req_accept, 0);
    tick();
    check("t6_accept0", req_accept, 4'b0001);
    check("t6_wdata0", bus_wdata, 16'hCAFE);
    check("t6_write0", bus_write, 1);
    req_valid = '0;
    bus_ack   = 1'b1;
    tick();
    check("t6_done0", req_done, 4'b0001);
    bus_ack = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
